// File: rtl/ram_128x8.sv
// Single-port 128x8 byte RAM bank. A rising edge on Enable starts an access that
// completes one clock later, signalled by MOC returning high.
module ram_128x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic       ReadWrite,
    input  logic [8:0] Address,
    input  logic [7:0] DataIn,
    output logic [7:0] DataOut,
    output logic       MOC
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_enQ;
    logic        r_rw;
    logic        r_moc;
    logic [6:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_dataOut;
    logic [7:0]  r_mem [0:127];

    logic        w_start;
    logic        w_latch;
    logic        w_memWrite;
    logic        w_mocNext;
    logic [7:0]  w_dataOutNext;
    logic        w_unused;

    // The upper address bits are deliberately ignored so addresses wrap modulo 128.
    assign w_unused = ^Address[8:7];

    assign w_start = Enable & ~r_enQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = ACCESS;
            ACCESS:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_latch       = 1'b0;
        w_memWrite    = 1'b0;
        w_mocNext     = r_moc;
        w_dataOutNext = r_dataOut;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_latch   = 1'b1;
                    w_mocNext = 1'b0;
                end
            end
            ACCESS: begin
                w_mocNext = 1'b1;
                if (r_rw) begin
                    w_dataOutNext = r_mem[r_addr];
                end else begin
                    w_memWrite = 1'b1;
                end
            end
            default: begin
                w_mocNext = 1'b0;
            end
        endcase
    end

    // Request fields are captured at the start edge so later input changes cannot
    // disturb the access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enQ     <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= 7'd0;
            r_data    <= 8'd0;
            r_moc     <= 1'b0;
            r_dataOut <= 8'd0;
        end else begin
            r_enQ     <= Enable;
            r_moc     <= w_mocNext;
            r_dataOut <= w_dataOutNext;
            if (w_latch) begin
                r_rw   <= ReadWrite;
                r_addr <= Address[6:0];
                r_data <= DataIn;
            end
        end
    end

    // Storage has no reset; a reset mid-access returns the FSM to IDLE so the
    // pending write never reaches the array.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign DataOut = r_dataOut;
    assign MOC     = r_moc;

endmodule

// File: tb/tb_ram_128x8.sv
// Self-checking bench for ram_128x8: a transaction-level memory model is compared
// against the DUT every cycle, plus directed literal checks.
module tb_ram_128x8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic       ReadWrite = 1'b0;
    logic [8:0] Address = 9'd0;
    logic [7:0] DataIn = 8'd0;
    logic [7:0] DataOut;
    logic       MOC;

    int nCompared = 0;
    int nMismatched = 0;
    bit checkOn = 1'b0;
    int mocFalls = 0;

    ram_128x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Enable    (Enable),
        .ReadWrite (ReadWrite),
        .Address   (Address),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MOC       (MOC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a;
        logic       rw;
        logic [7:0] d;
        int         due;
    } txn_t;

    logic [7:0] mMem [128];
    bit         mValid [128];
    bit         mPrevEn = 1'b0;
    logic [7:0] expData = 8'd0;
    bit         expDataKnown = 1'b1;
    bit         expMoc = 1'b0;
    int         edgeNo = 0;
    txn_t       pend[$];
    txn_t       txnCur;

    // Transaction model: a start enqueues a request that completes on the following edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            mPrevEn      = 1'b0;
            expMoc       = 1'b0;
            expData      = 8'd0;
            expDataKnown = 1'b1;
        end else begin
            edgeNo++;
            if (pend.size() > 0 && pend[0].due == edgeNo) begin
                txnCur = pend.pop_front();
                if (txnCur.rw) begin
                    expDataKnown = mValid[txnCur.a];
                    expData      = mMem[txnCur.a];
                end else begin
                    mMem[txnCur.a]   = txnCur.d;
                    mValid[txnCur.a] = 1'b1;
                end
                expMoc = 1'b1;
            end
            if (Enable && !mPrevEn) begin
                txnCur.a   = 7'(Address % 9'd128);
                txnCur.rw  = ReadWrite;
                txnCur.d   = DataIn;
                txnCur.due = edgeNo + 1;
                pend.push_back(txnCur);
                expMoc = 1'b0;
            end
            mPrevEn = Enable;
        end
    end

    always @(negedge MOC) mocFalls++;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("moc_model", {7'd0, MOC}, {7'd0, expMoc});
            if (expDataKnown) checkOutput("dataout_model", DataOut, expData);
        end
    end

    // One minimum-spacing access: Enable high for one edge, low for the next.
    task automatic applyStimulus(input logic rw, input logic [8:0] addr, input logic [7:0] data,
                                 output logic mocMid);
        Enable    = 1'b1;
        ReadWrite = rw;
        Address   = addr;
        DataIn    = data;
        @(posedge clk); #2;
        Enable = 1'b0;
        mocMid = MOC;
        @(posedge clk); #2;
    endtask

    logic       mid;
    int         fallsBefore;
    logic [7:0] bbData [4];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mMem[i]   = 8'd0;
            mValid[i] = 1'b0;
        end
        bbData[0] = 8'h11; bbData[1] = 8'h22; bbData[2] = 8'h33; bbData[3] = 8'h44;
        checkOn = 1'b1;
        $display("[TB] start");

        repeat (2) @(posedge clk); #2;
        checkOutput("reset_moc", {7'd0, MOC}, 8'h00);
        checkOutput("reset_dataout", DataOut, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #2;
        checkOutput("release_hold_moc", {7'd0, MOC}, 8'h00);
        checkOutput("release_hold_dataout", DataOut, 8'h00);

        applyStimulus(1'b0, 9'h005, 8'hA5, mid);
        checkOutput("write_moc_low", {7'd0, mid}, 8'h00);
        checkOutput("write_moc_high", {7'd0, MOC}, 8'h01);
        applyStimulus(1'b1, 9'h005, 8'h00, mid);
        checkOutput("read5_moc_low", {7'd0, mid}, 8'h00);
        checkOutput("read5_data", DataOut, 8'hA5);
        checkOutput("read5_moc", {7'd0, MOC}, 8'h01);

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_moc", {7'd0, MOC}, 8'h00);
        checkOutput("async_reset_dataout", DataOut, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        applyStimulus(1'b0, 9'h1FF, 8'h3C, mid);
        applyStimulus(1'b1, 9'h07F, 8'h00, mid);
        checkOutput("wrap_07f", DataOut, 8'h3C);
        applyStimulus(1'b1, 9'h0FF, 8'h00, mid);
        checkOutput("wrap_0ff", DataOut, 8'h3C);

        // Held strobe: one read, then scrambled inputs while Enable stays high.
        fallsBefore = mocFalls;
        Enable = 1'b1; ReadWrite = 1'b1; Address = 9'h005;
        repeat (5) begin
            @(posedge clk); #2;
            ReadWrite = 1'b0;
            Address   = 9'($urandom_range(0, 511));
            DataIn    = 8'($urandom_range(0, 255));
        end
        checkOutput("held_access_count", 8'(mocFalls - fallsBefore), 8'h01);
        checkOutput("held_moc", {7'd0, MOC}, 8'h01);
        checkOutput("held_data", DataOut, 8'hA5);
        Enable = 1'b0;
        @(posedge clk); #2;
        applyStimulus(1'b1, 9'h005, 8'h00, mid);
        checkOutput("held_nochange_5", DataOut, 8'hA5);
        applyStimulus(1'b1, 9'h07F, 8'h00, mid);
        checkOutput("held_nochange_7f", DataOut, 8'h3C);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 9'(i), bbData[i], mid);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 9'(i), 8'h00, mid);
            checkOutput("b2b_read", DataOut, bbData[i]);
        end
        applyStimulus(1'b0, 9'h004, 8'h55, mid);
        checkOutput("write_keeps_dataout", DataOut, 8'h44);

        // Reset lands between the start edge and the access edge of a write.
        applyStimulus(1'b0, 9'h009, 8'h01, mid);
        Enable = 1'b1; ReadWrite = 1'b0; Address = 9'h009; DataIn = 8'hFF;
        @(posedge clk); #2;
        rst_n  = 1'b0;
        Enable = 1'b0;
        #1;
        checkOutput("midwrite_reset_moc", {7'd0, MOC}, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        applyStimulus(1'b1, 9'h009, 8'h00, mid);
        checkOutput("midwrite_abandoned", DataOut, 8'h01);

        // Random traffic on a small address window, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            Enable    = 1'($urandom_range(0, 1));
            ReadWrite = 1'($urandom_range(0, 1));
            Address   = {2'($urandom_range(0, 3)), 3'b000, 4'($urandom_range(0, 15))};
            DataIn    = 8'($urandom_range(0, 255));
            rst_n     = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
        end
        @(posedge clk); #2;
        Enable = 1'b0;
        rst_n  = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        checkOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ram_128x8.md
# ram_128x8

Single-port 128-entry × 8-bit byte RAM bank with a strobe/acknowledge handshake. Four instances form the 32-bit memory subsystem: the access controller drives the same `ReadWrite` to every bank, per-bank `Enable`/`Address`/`DataIn`, and concatenates the byte outputs. The access controller waits on `MOC` (memory operation complete) before consuming `DataOut` or finishing a write.

## Interface
- No parameters. Depth is fixed at 128 and width at 8.
- `clk` input 1: the single clock. All state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `DataOut` output 8: read data. Registered and held until the next completed read.
- `MOC` output 1: memory operation complete. It is 0 while an access is in flight and 1 once that access completes.
- `Enable` input 1: access strobe. An access starts on its 0→1 transition, sampled on `clk`.
- `ReadWrite` input 1: 1 = read, 0 = write.
- `Address` input 9: byte address. Only `Address[6:0]` selects the entry. `Address[8:7]` is ignored, so addresses wrap modulo 128.
- `DataIn` input 8: write data.

## Operation
- Storage: 128 × 8 array. Contents are not affected by reset; after power-up they are undefined until written.
- Start detection: keep a register `en_q` holding the previous sampled `Enable`. A start happens on a clock edge where `Enable==1` and `en_q==0`.
  - Holding `Enable` high does not retrigger an access.
  - A new access requires `Enable` to return to 0 for at least one sampled edge.
- State machine:
  - `IDLE`: on a start, latch `Address[6:0]`, `ReadWrite` and `DataIn`; drive `MOC`<=0; go to `ACCESS`. With no start, hold all outputs.
  - `ACCESS`: one cycle.
    - Write: `mem[addr]`<=data. `DataOut` is unchanged.
    - Read: `DataOut`<=`mem[addr]`.
    - In both cases drive `MOC`<=1 and return to `IDLE`.
- Inputs changing after the start edge have no effect on the in-flight access, because they were latched.
- A read of an address written by an earlier completed access returns the new value.
- A start edge cannot coincide with `ACCESS`. The fastest legal re-strobe (`Enable` 1,0,1 on consecutive edges) lands its start edge in `IDLE`.
- Reset (`rst_n`=0, at any time, including mid-access):
  - Immediately forces `DataOut`=8'h00, `MOC`=0, state=`IDLE`, `en_q`=0.
  - An in-flight write is abandoned and memory is not modified.
  - After release, if `Enable` is already 1 on the first sampled edge, that edge counts as a start.

## Timing
- Edge n samples a start (`MOC` falls to 0 after edge n).
- Edge n+1 performs the read or write. After edge n+1, `MOC`=1, and for a read `DataOut` is valid.
- Latency is 2 clock edges from the sampled `Enable` rise to `MOC`=1 with data.
- `MOC` stays 1 from completion until the next start edge, which pulls it to 0 for exactly one cycle.
- Reset values: `DataOut`=0, `MOC`=0.
- Throughput: one access per 2 cycles maximum.

## Test plan
- Reset:
  - Assert `rst_n`=0 mid-cycle → `DataOut`=00 and `MOC`=0 immediately, without waiting for `clk`.
  - Release with `Enable`=0 → outputs hold.
- Write then read:
  - Write `Address`=9'h005, `DataIn`=8'hA5 → `MOC` goes 0 then 1 two edges after the strobe.
  - Read 9'h005 → `DataOut`=A5 with `MOC`=1 at the second edge after the strobe.
- Address wrap:
  - Write 8'h3C to 9'h1FF.
  - Read 9'h07F → 3C.
  - Read 9'h0FF → 3C.
- Held strobe:
  - Keep `Enable`=1 for 5 cycles after a read of 9'h005 → exactly one access.
  - `MOC` stays 1 and `DataOut` is unchanged.
  - Change `Address`/`DataIn` while `Enable` is held → no memory change.
- Back-to-back:
  - Write 11→addr 0, 22→addr 1, 33→addr 2, 44→addr 3 with minimum `Enable` 1,0 spacing.
  - Read them back in order → 11, 22, 33, 44.
  - A write does not disturb `DataOut` (it stays 44 after a subsequent write to addr 4).
- Reset mid-write:
  - Strobe a write of 8'hFF to addr 9 (addr 9 previously 8'h01), then assert `rst_n` before the `ACCESS` edge.
  - After release, a read of addr 9 returns 01.
